// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller and the execute-stage operand muxes.
package hazard_pkg;

    // Select encoding for the 3:1 SrcA/SrcB muxes in front of the ALU.
    localparam logic [1:0] FWD_RD = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one ALU source: the M stage wins over W, and x0 is never forwarded.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] Rs,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    output logic [1:0] Fwd
);

    always_comb begin
        // NOTE: default first so no path through the block leaves Fwd unassigned (no latch).
        Fwd = FWD_RD;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs)) begin
            Fwd = FWD_M;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs)) begin
            Fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Execute-stage hazard control: forwarding selects, load-use/branch/memory-wait stall and flush,
// memory-timeout recovery and a saturating stall performance counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             RegWriteE,
    input  logic             ResultSrcE,
    input  logic             MemWriteE,
    input  logic             PCSrcE,
    input  logic             mem_ready,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    logic [4:0]        RdM, RdW;
    logic              RegWriteM, RegWriteW, MemReqM;
    mem_state_t        state, next_state;
    logic [WAIT_W-1:0] wait_cnt, next_wait_cnt;
    logic              timeout, memstall, lwstall;

    fwd_sel u_fwd_a (
        .Rs(Rs1E), .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW), .Fwd(ForwardAE)
    );
    fwd_sel u_fwd_b (
        .Rs(Rs2E), .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW), .Fwd(ForwardBE)
    );

    // On timeout the stalled access is abandoned so the pipeline can drain.
    assign timeout  = (state == MEM_WAIT) && (wait_cnt == WAIT_MAX) && !mem_ready;
    assign memstall = MemReqM && !mem_ready && !timeout;
    assign lwstall  = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (memstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lwstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RdM       <= 5'd0;
            RegWriteM <= 1'b0;
            MemReqM   <= 1'b0;
            RdW       <= 5'd0;
            RegWriteW <= 1'b0;
        end else if (!StallM) begin
            RdM       <= RdE;
            RegWriteM <= RegWriteE;
            MemReqM   <= ResultSrcE | MemWriteE;
            RdW       <= RdM;
            RegWriteW <= RegWriteM;
        end
    end

    always_comb begin
        next_state    = state;
        next_wait_cnt = wait_cnt;
        unique case (state)
            RUN: begin
                if (memstall) begin
                    next_state    = MEM_WAIT;
                    next_wait_cnt = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready || timeout) begin
                    next_state    = RUN;
                    next_wait_cnt = '0;
                end else begin
                    next_wait_cnt = wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                next_state    = RUN;
                next_wait_cnt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_err     <= 1'b0;
            stall_count <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait_cnt;
            if (timeout) begin
                mem_err <= 1'b1;
            end
            if (StallF && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle memory-wait sequences,
// and randomized traffic against a cycle-level reference model.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic RegWriteE, ResultSrcE, MemWriteE, PCSrcE, mem_ready;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, mem_err;
    logic [CNT_W-1:0] stall_count;

    // Second instance with a 2-bit counter to exercise saturation.
    logic [1:0] s_fa, s_fb;
    logic s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_err;
    logic [1:0] s_cnt;

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
        .mem_ready(mem_ready), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF),
        .StallD(StallD), .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
        .mem_err(mem_err), .stall_count(stall_count)
    );

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
        .mem_ready(mem_ready), .ForwardAE(s_fa), .ForwardBE(s_fb), .StallF(s_sf),
        .StallD(s_sd), .StallE(s_se), .StallM(s_sm), .FlushD(s_fd), .FlushE(s_fe),
        .mem_err(s_err), .stall_count(s_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [3:0] st, input logic [1:0] fl);
        check({tag, " ForwardAE"}, 64'(ForwardAE), 64'(fa));
        check({tag, " ForwardBE"}, 64'(ForwardBE), 64'(fb));
        check({tag, " stalls FDEM"}, 64'({StallF, StallD, StallE, StallM}), 64'(st));
        check({tag, " flushes DE"}, 64'({FlushD, FlushE}), 64'(fl));
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0;
        RegWriteE = 1'b0; ResultSrcE = 1'b0; MemWriteE = 1'b0; PCSrcE = 1'b0;
        mem_ready = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        clear_inputs();
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs(tag, 2'b00, 2'b00, 4'b0000, 2'b00);
        check({tag, " mem_err"}, 64'(mem_err), 64'd0);
        check({tag, " stall_count"}, 64'(stall_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_ready = 1'b1;
    endtask

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic       rwe, lde, mwe, pcs;
        logic [1:0] fa, fb;
        logic [3:0] st;
        logic [1:0] fl;
    } vec_t;

    // Reference model state: shadow M/W contents, consecutive stalled cycles of the current access.
    logic [4:0] m_rd, w_rd;
    logic       m_we, m_mem, w_we, m_err;
    int         waited;
    longint     m_cnt;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (m_we && m_rd != 0 && m_rd == rs) return 2'b10;
        if (w_we && w_rd != 0 && w_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    initial begin
        vec_t vecs[14];
        logic pending, tmo, ms, lw;
        logic [3:0] e_st;
        logic [1:0] e_fl;

        //          rs1d  rs2d  rs1e  rs2e  rde   rwe   lde   mwe   pcs    fa     fb     st       fl
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[1]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 4'b0000, 2'b00};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 2'b00};
        vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[8]  = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 4'b0000, 2'b00};
        vecs[9]  = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4'b1100, 2'b01};
        vecs[10] = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 2'b00};
        vecs[12] = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 4'b0000, 2'b11};
        vecs[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00};

        clear_inputs();
        do_reset("reset0");

        for (int i = 0; i < 14; i++) begin
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            RdE = vecs[i].rde; RegWriteE = vecs[i].rwe; ResultSrcE = vecs[i].lde;
            MemWriteE = vecs[i].mwe; PCSrcE = vecs[i].pcs; mem_ready = 1'b1;
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].fa, vecs[i].fb, vecs[i].st, vecs[i].fl);
            next_cycle();
        end

        // Load held in M for three wait cycles; branch and load-use requests are ignored meanwhile.
        do_reset("reset1");
        ResultSrcE = 1'b1; RegWriteE = 1'b1; RdE = 5'd9;
        @(negedge clk);
        check_outs("ld_issue", 2'b00, 2'b00, 4'b0000, 2'b00);
        next_cycle();
        clear_inputs();
        mem_ready = 1'b0;
        Rs1E = 5'd9;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                PCSrcE = 1'b1; ResultSrcE = 1'b1; RdE = 5'd6; Rs1D = 5'd6;
            end else begin
                PCSrcE = 1'b0; ResultSrcE = 1'b0; RdE = 5'd0; Rs1D = 5'd0;
            end
            @(negedge clk);
            check_outs($sformatf("memwait%0d", k), 2'b10, 2'b00, 4'b1111, 2'b00);
            next_cycle();
        end
        PCSrcE = 1'b0; ResultSrcE = 1'b0; RdE = 5'd0; Rs1D = 5'd0;
        mem_ready = 1'b1;
        @(negedge clk);
        check_outs("mem_done", 2'b10, 2'b00, 4'b0000, 2'b00);
        check("mem_done stall_count", 64'(stall_count), 64'd3);
        next_cycle();
        @(negedge clk);
        check("after_done stall_count", 64'(stall_count), 64'd3);
        check("after_done mem_err", 64'(mem_err), 64'd0);

        // Memory never answers: 16 stalled cycles, forced release, sticky error.
        do_reset("reset2");
        ResultSrcE = 1'b1; RdE = 5'd2;
        next_cycle();
        clear_inputs();
        mem_ready = 1'b0;
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            @(negedge clk);
            check($sformatf("tmo_wait%0d stalls", k), 64'({StallF, StallD, StallE, StallM}), 64'hF);
            next_cycle();
        end
        @(negedge clk);
        check_outs("tmo_release", 2'b00, 2'b00, 4'b0000, 2'b00);
        check("tmo_release mem_err", 64'(mem_err), 64'd0);
        next_cycle();
        @(negedge clk);
        check("tmo mem_err", 64'(mem_err), 64'd1);
        check("tmo stall_count", 64'(stall_count), 64'd16);
        check("tmo sat_count", 64'(s_cnt), 64'd3);
        check("tmo stalls", 64'({StallF, StallD, StallE, StallM}), 64'h0);
        repeat (3) next_cycle();
        @(negedge clk);
        check("tmo mem_err sticky", 64'(mem_err), 64'd1);

        // A new wait, then reset asserted mid-cycle drops the stalls at once.
        next_cycle();
        MemWriteE = 1'b1; mem_ready = 1'b1;
        next_cycle();
        MemWriteE = 1'b0; mem_ready = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_mid stalled", 64'({StallF, StallD, StallE, StallM}), 64'hF);
        check("rst_mid mem_err before", 64'(mem_err), 64'd1);
        rst = 1'b0;
        #1;
        check("rst_mid stalls", 64'({StallF, StallD, StallE, StallM}), 64'h0);
        check("rst_mid mem_err", 64'(mem_err), 64'd0);
        check("rst_mid stall_count", 64'(stall_count), 64'd0);

        // Randomized traffic against the reference model.
        do_reset("reset3");
        m_rd = '0; w_rd = '0; m_we = 1'b0; w_we = 1'b0; m_mem = 1'b0; m_err = 1'b0;
        waited = 0; m_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE = 5'($urandom_range(0, 3));
            RegWriteE = ($urandom_range(0, 1) == 1);
            ResultSrcE = ($urandom_range(0, 2) == 0);
            MemWriteE = ($urandom_range(0, 3) == 0);
            PCSrcE = ($urandom_range(0, 7) == 0);
            if (i >= 1500 && i < 2200) mem_ready = ($urandom_range(0, 19) == 0);
            else mem_ready = ($urandom_range(0, 3) != 0);

            pending = m_mem && !mem_ready;
            tmo = pending && (waited == MEM_TIMEOUT);
            ms = pending && !tmo;
            lw = ResultSrcE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            if (ms) begin e_st = 4'b1111; e_fl = 2'b00; end
            else if (PCSrcE) begin e_st = 4'b0000; e_fl = 2'b11; end
            else if (lw) begin e_st = 4'b1100; e_fl = 2'b01; end
            else begin e_st = 4'b0000; e_fl = 2'b00; end

            @(negedge clk);
            check_outs($sformatf("rnd%0d", i), ref_fwd(Rs1E), ref_fwd(Rs2E), e_st, e_fl);
            check($sformatf("rnd%0d mem_err", i), 64'(mem_err), 64'(m_err));
            check($sformatf("rnd%0d stall_count", i), 64'(stall_count), 64'(m_cnt));

            if (!ms) begin
                w_rd = m_rd; w_we = m_we;
                m_rd = RdE; m_we = RegWriteE; m_mem = ResultSrcE | MemWriteE;
            end
            waited = ms ? waited + 1 : 0;
            if (tmo) m_err = 1'b1;
            if (e_st[3]) m_cnt++;
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
